clk_divider_prog: RTL and testbench
===================================

// Module: clk_divider_prog
// PURPOSE
//  Runtime-programmable integer clock divider, successor to the fixed-ratio divider.
//  Produces a divided square wave plus a one-cycle period strobe from i_clk.
//  The divisor (and optionally the high time) is reloadable at run time and is applied glitch-free at the period boundary.
//  Feeds slow peripherals (UART/SPI bit clocks, LED scan) as a clock-enable source.
// PARAMETERS
//  DIV_W      8   width of divisor/counter; max divisor 2**DIV_W-1
//  DIV_RESET  4   divisor in force after reset; must be 2..2**DIV_W-1
// PORTS
//  i_clk       in   1      system clock; all logic on posedge
//  i_rst       in   1      synchronous, active-high reset
//  i_en        in   1      1 = count; 0 = freeze counter and outputs
//  i_div       in   DIV_W  new divisor N, sampled when i_div_load=1
//  i_div_load  in   1      single-cycle load strobe
//  o_clk       out  1      divided clock, period N i_clk cycles
//  o_tick      out  1      1-cycle strobe on last cycle of each period
//  o_cnt       out  DIV_W  current phase count, 0..N-1
//  o_div       out  DIV_W  divisor currently in force
//  o_pending   out  1      a loaded divisor awaits the next boundary
// BEHAVIOUR
//  - Reset (i_rst=1 at posedge): o_cnt=0, o_clk=0, o_div=DIV_RESET, pending reg=DIV_RESET, o_pending=0.
//    Reset mid-period aborts it and discards any pending load.
//  - Clamp: a loaded i_div of 0 or 1 is stored as 2. No other clamping.
//  - Counter: if i_en=1, o_cnt <= (o_cnt==N-1) ? 0 : o_cnt+1. If i_en=0, all state holds (loads still captured).
//  - Boundary (B): cycle where o_cnt==N-1 and i_en=1.
//    o_tick = B, combinational from registers; no tick while frozen.
//  - Duty: H = floor(N/2). o_clk is registered and equals (o_cnt >= N-H) at every cycle.
//    Examples: N=4 -> o_cnt 0,1 low, 2,3 high. N=5 -> 0,1,2 low, 3,4 high.
//    o_clk falls on the cycle after B.
//  - Load: i_div_load=1 captures clamp(i_div) into the pending reg and sets o_pending=1.
//    A later load before the boundary overwrites it (last wins).
//  - Apply: at B with o_pending=1 (or i_div_load=1 in the same cycle), o_div <= the new value.
//    The same-cycle i_div takes priority over the pending reg. o_pending clears. Next o_cnt=0.
//    The new period starts low. No truncated or runt periods are ever produced.
//  - Load while i_en=0: held pending until counting resumes and reaches B.
//  - Latency: load -> effect = remaining cycles of the current period (max N_old).
// CONFIGURATION
//  `define CLK_DIV_DUTY_EN
//    Adds port i_high (in, DIV_W), captured with i_div_load and applied at B alongside o_div.
//    H = i_high clamped to 1..N-1; value 0 selects floor(N/2). Reset H = floor(DIV_RESET/2).
//  Without the macro: no i_high port; H = floor(N/2) always.
// TESTING
//  1. Reset, i_en=1, no load -> o_div=4, o_cnt 0,1,2,3 repeating, o_clk 0,0,1,1, o_tick on cnt=3 only.
//  2. Load N=5, wait for boundary -> o_clk low 3 / high 2; o_tick every 5 cycles; o_pending 1 -> 0 at B.
//  3. Load 6 at cnt=1 of N=4 -> cnt 2,3 complete at N=4, then period 6 (low 3 / high 3). No runt pulse.
//  4. Load 7, then 9 before the boundary -> 9 applied; also load 8 exactly at B -> 8 applied at that B.
//  5. i_en=0 for 10 cycles mid-period -> o_cnt/o_clk frozen, o_tick=0; resumes from the held count.
//     Load 0 -> o_div=2, o_clk toggles every cycle.
//  6. i_rst pulse mid-period with a pending load -> next cycle o_cnt=0, o_clk=0, o_div=4, o_pending=0.
//     [DUTY_EN] N=10, i_high=3 -> 7 low / 3 high; i_high=12 -> H=9.

Source files
------------

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable integer clock divider with period strobe.
// Optional CLK_DIV_DUTY_EN adds a programmable high time (i_high) applied at the period boundary.
module clk_divider_prog #(
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_div_load,
`ifdef CLK_DIV_DUTY_EN
    input  logic [DIV_W-1:0] i_high,
`endif
    output logic             o_clk,
    output logic             o_tick,
    output logic [DIV_W-1:0] o_cnt,
    output logic [DIV_W-1:0] o_div,
    output logic             o_pending
);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DIV_RESET);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_div_q, pend_div_d, high_d, new_div;
    logic             clk_q, clk_d, pend_q, pend_d, apply;
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < TWO) ? TWO : d;
    endfunction
`ifdef CLK_DIV_DUTY_EN
    logic [DIV_W-1:0] high_q, pend_high_q, pend_high_d, new_high;
    // A zero high time means "half the period"; anything else is kept inside 1..N-1.
    function automatic logic [DIV_W-1:0] resolve_h(input logic [DIV_W-1:0] hv, input logic [DIV_W-1:0] n);
        return (hv == '0) ? (n >> 1) : (hv > n - ONE) ? n - ONE : hv;
    endfunction
`endif
    always_comb begin
        o_tick     = i_en && (cnt_q == div_q - ONE);
        new_div    = i_div_load ? clamp_div(i_div) : pend_div_q;
        apply      = o_tick && (i_div_load || pend_q);
        div_d      = apply ? new_div : div_q;
        cnt_d      = !i_en ? cnt_q : o_tick ? '0 : cnt_q + ONE;
        pend_d     = o_tick ? 1'b0 : (i_div_load ? 1'b1 : pend_q);
        pend_div_d = i_div_load ? clamp_div(i_div) : pend_div_q;
`ifdef CLK_DIV_DUTY_EN
        new_high    = i_div_load ? i_high : pend_high_q;
        pend_high_d = i_div_load ? i_high : pend_high_q;
        high_d      = apply ? resolve_h(new_high, new_div) : high_q;
`else
        high_d      = div_d >> 1;
`endif
        // Registered output tracks the phase it will show next, so it never lags the counter.
        clk_d      = cnt_d >= div_d - high_d;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q      <= '0;
            clk_q      <= 1'b0;
            div_q      <= RST_DIV;
            pend_div_q <= RST_DIV;
            pend_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            clk_q      <= clk_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
        end
    end
`ifdef CLK_DIV_DUTY_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            high_q      <= RST_DIV >> 1;
            pend_high_q <= '0;
        end else begin
            high_q      <= high_d;
            pend_high_q <= pend_high_d;
        end
    end
`endif
    assign o_clk     = clk_q;
    assign o_cnt     = cnt_q;
    assign o_div     = div_q;
    assign o_pending = pend_q;
endmodule

// File: tb/tb_clk_divider_prog.sv
// tb_clk_divider_prog: randomized and directed checks of clk_divider_prog against a period-level model.
module tb_clk_divider_prog;
    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, load = 1'b0;
    logic [7:0] div = '0, high = '0;
    logic       o_clk, o_tick, o_pending;
    logic [7:0] o_cnt, o_div;
    int checks = 0, errors = 0;
    int m_cnt = 0, m_n = 4, m_h = 2, m_pend = 0, m_pval = 4, m_phv = 0;

    clk_divider_prog #(.DIV_W(8), .DIV_RESET(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_div(div), .i_div_load(load),
`ifdef CLK_DIV_DUTY_EN
        .i_high(high),
`endif
        .o_clk(o_clk), .o_tick(o_tick), .o_cnt(o_cnt), .o_div(o_div), .o_pending(o_pending)
    );

    always #5 clk = ~clk;

    function automatic int clampn(int v);
        return v < 2 ? 2 : v;
    endfunction

    function automatic int hsel(int hv, int n);
`ifdef CLK_DIV_DUTY_EN
        return hv == 0 ? n / 2 : (hv > n - 1 ? n - 1 : hv);
`else
        return n / 2;
`endif
    endfunction

    // Expected {cnt, clk, tick, div, pending}: high for the last H cycles of every N-cycle period.
    function automatic logic [18:0] expv();
        return {8'(m_cnt), 1'(m_cnt >= m_n - m_h), 1'(en && m_cnt == m_n - 1), 8'(m_n), 1'(m_pend)};
    endfunction

    task automatic drive(input logic r, input logic e, input logic l, input int d, input int hv);
        rst = r; en = e; load = l; div = 8'(d); high = 8'(hv);
        #1;
    endtask

    task automatic adv();
        int b;
        if (rst) begin
            m_cnt = 0; m_n = 4; m_h = 2; m_pend = 0; m_pval = 4;
        end else begin
            b = (en && m_cnt == m_n - 1) ? 1 : 0;
            if (b != 0) begin
                if (load) begin
                    m_n = clampn(int'(div)); m_h = hsel(int'(high), m_n);
                end else if (m_pend != 0) begin
                    m_n = m_pval; m_h = hsel(m_phv, m_n);
                end
                m_pend = 0; m_cnt = 0;
            end else begin
                if (load) begin
                    m_pval = clampn(int'(div)); m_phv = int'(high); m_pend = 1;
                end
                if (en) m_cnt = m_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0); adv(); adv();
        drive(0, 1, 0, 0, 0);
        checks++;
        if ({o_cnt, o_clk, o_div, o_pending} !== {8'd0, 1'b0, 8'd4, 1'b0}) begin
            errors++;
            $display("FAIL reset got cnt=%0d clk=%b div=%0d pend=%b req 0 0 4 0", o_cnt, o_clk, o_div, o_pending);
        end
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 0, 0, 0);
            checks++;
            if ({o_cnt, o_clk, o_tick} !== {8'(i % 4), 1'(i % 4 >= 2), 1'(i % 4 == 3)}) begin
                errors++;
                $display("FAIL default_div4 i=%0d got cnt=%0d clk=%b tick=%b req %0d %b %b", i, o_cnt, o_clk, o_tick, i % 4, i % 4 >= 2, i % 4 == 3);
            end
            adv();
        end
    endtask

    task automatic test_load5();
        int ticks[$];
        int highs = 0;
        drive(0, 1, 1, 5, 0); adv();
        for (int i = 0; i < 30; i++) begin
            drive(0, 1, 0, 0, 0);
            checks++;
            if ({o_cnt, o_clk, o_tick, o_div, o_pending} !== expv()) begin
                errors++;
                $display("FAIL load5 i=%0d got %h req %h", i, {o_cnt, o_clk, o_tick, o_div, o_pending}, expv());
            end
            if (o_tick) ticks.push_back(i);
            if (i >= 20 && o_clk) highs++;
            adv();
        end
        checks++;
        if (ticks.size() < 3 || ticks[$] - ticks[$-1] != 5 || highs != 4) begin
            errors++;
            $display("FAIL load5_period ticks=%0d high_cycles=%0d req spacing 5 high 4", ticks.size(), highs);
        end
    endtask

    task automatic test_midload();
        int w = 0;
        drive(1, 0, 0, 0, 0); adv();
        drive(0, 1, 0, 0, 0);
        while (o_cnt != 8'd1 && w < 20) begin adv(); w++; end
        checks++;
        if (o_cnt != 8'd1) begin
            errors++;
            $display("FAIL midload_wait got cnt=%0d req 1", o_cnt);
        end
        drive(0, 1, 1, 6, 0); adv();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 0, 0);
            checks++;
            if ({o_cnt, o_clk, o_tick, o_div, o_pending} !== expv()) begin
                errors++;
                $display("FAIL midload i=%0d got %h req %h", i, {o_cnt, o_clk, o_tick, o_div, o_pending}, expv());
            end
            adv();
        end
    endtask

    task automatic test_back_to_back();
        int w = 0;
        drive(0, 1, 1, 7, 0); adv();
        drive(0, 1, 1, 9, 0); adv();
        drive(0, 1, 0, 0, 0);
        while (!o_tick && w < 20) begin adv(); w++; end
        adv();
        checks++;
        if ({o_div, o_pending, o_cnt} !== {8'd9, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL last_wins got div=%0d pend=%b cnt=%0d req 9 0 0", o_div, o_pending, o_cnt);
        end
        w = 0;
        drive(0, 1, 0, 0, 0);
        while (!o_tick && w < 20) begin adv(); w++; end
        drive(0, 1, 1, 8, 0); adv();
        checks++;
        if ({o_div, o_pending, o_cnt} !== {8'd8, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL load_at_b got div=%0d pend=%b cnt=%0d req 8 0 0", o_div, o_pending, o_cnt);
        end
    endtask

    task automatic test_freeze();
        logic [7:0] held;
        drive(0, 1, 0, 0, 0); adv(); adv(); adv();
        held = o_cnt;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, i == 4, 0, 0);
            checks++;
            if ({o_cnt, o_tick, o_clk, o_cnt} !== {held, 1'b0, 1'(m_cnt >= m_n - m_h), 8'(m_cnt)}) begin
                errors++;
                $display("FAIL freeze i=%0d got cnt=%0d tick=%b clk=%b req cnt=%0d tick=0", i, o_cnt, o_tick, o_clk, held);
            end
            adv();
        end
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 0, 0);
            checks++;
            if ({o_cnt, o_clk, o_tick, o_div, o_pending} !== expv()) begin
                errors++;
                $display("FAIL resume i=%0d got %h req %h", i, {o_cnt, o_clk, o_tick, o_div, o_pending}, expv());
            end
            adv();
        end
        checks++;
        if (o_div !== 8'd2) begin
            errors++;
            $display("FAIL clamp0 got div=%0d req 2", o_div);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 1, 11, 0); adv();
        drive(1, 1, 0, 0, 0); adv();
        drive(0, 1, 0, 0, 0);
        checks++;
        if ({o_cnt, o_clk, o_div, o_pending} !== {8'd0, 1'b0, 8'd4, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got cnt=%0d clk=%b div=%0d pend=%b req 0 0 4 0", o_cnt, o_clk, o_div, o_pending);
        end
    endtask

`ifdef CLK_DIV_DUTY_EN
    task automatic test_duty();
        drive(1, 0, 0, 0, 0); adv();
        drive(0, 1, 1, 10, 3); adv();
        for (int i = 0; i < 40; i++) begin
            drive(0, 1, i == 20, 10, 12);
            checks++;
            if ({o_cnt, o_clk, o_tick, o_div, o_pending} !== expv()) begin
                errors++;
                $display("FAIL duty i=%0d got %h req %h", i, {o_cnt, o_clk, o_tick, o_div, o_pending}, expv());
            end
            adv();
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 12), $urandom_range(0, 14));
            checks++;
            if ({o_cnt, o_clk, o_tick, o_div, o_pending} !== expv()) begin
                errors++;
                $display("FAIL random i=%0d got %h req %h", i, {o_cnt, o_clk, o_tick, o_div, o_pending}, expv());
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_load5();
        test_midload();
        test_back_to_back();
        test_freeze();
        test_reset_mid();
`ifdef CLK_DIV_DUTY_EN
        test_duty();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
